// File: rtl/sw_seq_feeder.sv
// Purpose: source-side driver for the Smith-Waterman core; buffers the s/t
//          sequences, resets the core, streams INPUT_LENGTH symbol pairs and
//          captures the core's max score (or flags a timeout).
// Ports:   clk/reset; wr_* host buffer write port; start/busy/done/error/result
//          host control and status; sw_rst/valid/data_s/data_t to the core;
//          sw_finish/sw_max from the core. All outputs are registered.
module sw_seq_feeder #(
  parameter int INPUT_LENGTH = 256,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_CYC  = 2048,
  parameter int SCORE_W      = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [1:0]         wr_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [SCORE_W-1:0] result,
  output logic               sw_rst,
  output logic               valid,
  output logic [1:0]         data_s,
  output logic [1:0]         data_t,
  input  logic               sw_finish,
  input  logic [SCORE_W-1:0] sw_max
);

  localparam int IDX_W = ADDR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0] sbuf [INPUT_LENGTH];
  logic [1:0] tbuf [INPUT_LENGTH];

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic [TO_W-1:0]  tcnt;
  logic             last_sym;
  logic             timeout_hit;
  logic             wr_ok;

  logic               busy_d, done_d, error_d, sw_rst_d, valid_d;
  logic [SCORE_W-1:0] result_d;
  logic [1:0]         data_s_d, data_t_d;

  assign idx_inc     = idx + IDX_W'(1);
  assign last_sym    = (idx == IDX_W'(INPUT_LENGTH - 1));
  assign timeout_hit = (tcnt == TO_W'(TIMEOUT_CYC - 1));

  // Writes are frozen for the whole run so the stream is a stable snapshot.
  // A write in the same IDLE cycle as start still lands, since busy is
  // only raised by that edge.
  assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < IDX_W'(INPUT_LENGTH));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) tbuf[wr_addr] <= wr_data;
      else        sbuf[wr_addr] <= wr_data;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_STREAM;
      S_STREAM: if (last_sym) state_nxt = S_WAIT;
      S_WAIT:   if (sw_finish || timeout_hit) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // idx holds the index being presented during STREAM; tcnt counts WAIT
  // cycles and saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      tcnt <= '0;
    end else begin
      idx  <= (state == S_STREAM) ? idx_inc : '0;
      if (state != S_WAIT)  tcnt <= '0;
      else if (tcnt != '1)  tcnt <= tcnt + TO_W'(1);
    end
  end

  // Output logic: values the output registers take at the next edge, so
  // each registered output lines up with the state it belongs to.
  always_comb begin
    busy_d   = busy;
    done_d   = done;
    error_d  = error;
    result_d = result;
    sw_rst_d = 1'b0;
    valid_d  = 1'b0;
    data_s_d = 2'b00;
    data_t_d = 2'b00;
    case (state)
      S_IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          done_d   = 1'b0;
          error_d  = 1'b0;
          result_d = '0;
          sw_rst_d = 1'b1;
        end
      end
      S_CLEAR: begin
        valid_d  = 1'b1;
        data_s_d = sbuf[0];
        data_t_d = tbuf[0];
      end
      S_STREAM: begin
        if (!last_sym) begin
          valid_d  = 1'b1;
          data_s_d = sbuf[idx_inc[ADDR_W-1:0]];
          data_t_d = tbuf[idx_inc[ADDR_W-1:0]];
        end
      end
      S_WAIT: begin
        // finish takes priority over a coinciding timeout
        if (sw_finish) begin
          result_d = sw_max;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else if (timeout_hit) begin
          error_d  = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      result <= '0;
      sw_rst <= 1'b0;
      valid  <= 1'b0;
      data_s <= 2'b00;
      data_t <= 2'b00;
    end else begin
      busy   <= busy_d;
      done   <= done_d;
      error  <= error_d;
      result <= result_d;
      sw_rst <= sw_rst_d;
      valid  <= valid_d;
      data_s <= data_s_d;
      data_t <= data_t_d;
    end
  end

endmodule

// File: tb/tb_sw_seq_feeder.sv
module tb_sw_seq_feeder;
  localparam int L  = 256;
  localparam int AW = 8;
  localparam int T  = 2048;
  localparam int SW = 12;

  logic          clk = 0;
  logic          reset = 1;
  logic          wr_en = 0, wr_sel = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [1:0]    wr_data = '0;
  logic          start = 0;
  logic          busy, done, error, sw_rst, valid;
  logic [SW-1:0] result;
  logic [1:0]    data_s, data_t;
  logic          sw_finish = 0;
  logic [SW-1:0] sw_max = '0;

  sw_seq_feeder #(.INPUT_LENGTH(L), .ADDR_W(AW), .TIMEOUT_CYC(T), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .error(error),
    .result(result), .sw_rst(sw_rst), .valid(valid), .data_s(data_s), .data_t(data_t),
    .sw_finish(sw_finish), .sw_max(sw_max)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference buffer contents as the host believes them to be.
  logic [1:0] ms [L];
  logic [1:0] mt [L];

  // Observations of one run, cycle 1 = first cycle after the start edge.
  int obs_rst_first, obs_rst_cnt, obs_v_first, obs_v_last, obs_v_cnt;
  int obs_data_bad, obs_busy_bad, obs_done_cyc;
  logic obs_busy_at_done, obs_err_at_done;
  logic [SW-1:0] obs_res_at_done;

  task automatic wr_one(input logic sel, input logic [AW-1:0] a, input logic [1:0] d);
    @(negedge clk);
    wr_en = 1; wr_sel = sel; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 0;
    if (sel) mt[a] = d; else ms[a] = d;
  endtask

  // mode 0: i%4 in both; mode 1: random
  task automatic load_bufs(input int mode);
    for (int i = 0; i < L; i++) begin
      wr_one(1'b0, AW'(i), (mode == 0) ? 2'(i % 4) : 2'($urandom_range(0, 3)));
      wr_one(1'b1, AW'(i), (mode == 0) ? 2'(i % 4) : 2'($urandom_range(0, 3)));
    end
  endtask

  // Pulses start, plays the core responder (raise finish fin_after cycles into
  // WAIT, never if negative) and records what the DUT did until done.
  task automatic run(input int fin_after, input logic [SW-1:0] mx, input int inj_cyc,
                     input bit pre_wr, input logic pre_sel, input logic [AW-1:0] pre_addr,
                     input logic [1:0] pre_data);
    logic [1:0] es [L];
    logic [1:0] et [L];
    int wait_start;
    int k;
    @(negedge clk);
    start = 1;
    if (pre_wr) begin
      wr_en = 1; wr_sel = pre_sel; wr_addr = pre_addr; wr_data = pre_data;
      if (pre_sel) mt[pre_addr] = pre_data; else ms[pre_addr] = pre_data;
    end
    es = ms; et = mt;
    @(posedge clk); #1;
    start = 0; wr_en = 0;
    obs_rst_first = -1; obs_rst_cnt = 0; obs_v_first = -1; obs_v_last = -1; obs_v_cnt = 0;
    obs_data_bad = 0; obs_busy_bad = 0; obs_done_cyc = -1;
    obs_busy_at_done = 1'bx; obs_err_at_done = 1'bx; obs_res_at_done = 'x;
    wait_start = -1; k = 0;
    sw_max = mx; sw_finish = 0;
    for (int c = 1; c <= L + T + 20; c++) begin
      @(negedge clk);
      if (inj_cyc == c) begin
        wr_en = 1; wr_sel = 0; wr_addr = AW'(5); wr_data = 2'd3; start = 1;
      end else if (inj_cyc + 1 == c) begin
        wr_en = 0; start = 0;
      end
      if (sw_rst === 1'b1) begin
        if (obs_rst_cnt == 0) obs_rst_first = c;
        obs_rst_cnt++;
      end
      if (valid === 1'b1) begin
        if (obs_v_cnt == 0) obs_v_first = c;
        obs_v_last = c;
        if (k < L && (data_s !== es[k] || data_t !== et[k])) obs_data_bad++;
        k++; obs_v_cnt++;
      end else if (data_s !== 2'b00 || data_t !== 2'b00) begin
        obs_data_bad++;
      end
      if (done === 1'b1) begin
        obs_done_cyc = c; obs_busy_at_done = busy; obs_err_at_done = error; obs_res_at_done = result;
        break;
      end
      if (busy !== 1'b1) obs_busy_bad++;
      if (valid !== 1'b1 && obs_v_cnt >= L && wait_start < 0) wait_start = c;
      sw_finish = (fin_after >= 0 && wait_start >= 0 && (c - wait_start) >= fin_after);
    end
    wr_en = 0; start = 0;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, sw_rst, valid, data_s, data_t, result} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b/%b/%b/%b/%b/%0d/%0d/%0d want all zero",
               busy, done, error, sw_rst, valid, data_s, data_t, result);
    end
    reset = 0;
  endtask

  task automatic test_stream;
    load_bufs(0);
    run(0, 12'h055, -1, 0, 0, '0, '0);
    sw_finish = 0;
    chk("stream_rst_cycle", obs_rst_first, 1);
    chk("stream_rst_count", obs_rst_cnt, 1);
    chk("stream_first_valid", obs_v_first, 2);
    chk("stream_last_valid", obs_v_last, L + 1);
    chk("stream_valid_count", obs_v_cnt, L);
    chk("stream_data_bad", obs_data_bad, 0);
    chk("stream_done_cycle", obs_done_cyc, L + 3);
    chk("stream_result", int'(obs_res_at_done), 'h055);
  endtask

  task automatic test_finish;
    load_bufs(1);
    run(400, 12'h123, -1, 0, 0, '0, '0);
    chk("finish_done_cycle", obs_done_cyc, L + 2 + 400 + 1);
    chk("finish_result", int'(obs_res_at_done), 'h123);
    chk("finish_busy_at_done", int'(obs_busy_at_done), 0);
    chk("finish_error", int'(obs_err_at_done), 0);
    chk("finish_busy_during_run", obs_busy_bad, 0);
    chk("finish_data_bad", obs_data_bad, 0);
    // finish stays high into IDLE; it must be ignored and status must hold
    repeat (3) @(negedge clk);
    chk("finish_done_sticky", int'(done), 1);
    chk("finish_result_sticky", int'(result), 'h123);
    chk("finish_idle_not_busy", int'(busy), 0);
    chk("finish_idle_no_valid", int'(valid), 0);
    sw_finish = 0;
  endtask

  task automatic test_timeout;
    run(-1, 12'h7ff, -1, 0, 0, '0, '0);
    chk("timeout_done_cycle", obs_done_cyc, L + 2 + T);
    chk("timeout_error", int'(obs_err_at_done), 1);
    chk("timeout_result", int'(obs_res_at_done), 0);
    chk("timeout_busy_at_done", int'(obs_busy_at_done), 0);
  endtask

  task automatic test_busy_write;
    wr_one(1'b0, AW'(5), 2'd0);
    run(10, 12'h0aa, 3, 0, 0, '0, '0);
    sw_finish = 0;
    chk("busywr_data_bad", obs_data_bad, 0);
    chk("busywr_rst_count", obs_rst_cnt, 1);
    chk("busywr_valid_count", obs_v_cnt, L);
    chk("busywr_done_cycle", obs_done_cyc, L + 2 + 10 + 1);
  endtask

  // Back-to-back run; a write in the start cycle must land first. The model
  // still holds sbuf[5]=0, so the dropped busy write is confirmed here too.
  task automatic test_back_to_back;
    logic [1:0] nv;
    nv = ~mt[0];
    run(7, SW'($urandom_range(0, 4095)), -1, 1, 1'b1, AW'(0), nv);
    sw_finish = 0;
    chk("b2b_data_bad", obs_data_bad, 0);
    chk("b2b_first_valid", obs_v_first, 2);
    chk("b2b_done_cycle", obs_done_cyc, L + 2 + 7 + 1);
  endtask

  task automatic test_mid_reset;
    bit seen;
    seen = 0;
    @(negedge clk);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int c = 1; c <= 102; c++) begin
      @(negedge clk);
      if (c == 102) begin
        seen = 1;
        checks++;
        if (valid !== 1'b1 || data_s !== ms[100] || data_t !== mt[100]) begin
          errors++;
          $display("FAIL midrst_index100 got v=%b s=%0d t=%0d want v=1 s=%0d t=%0d",
                   valid, data_s, data_t, ms[100], mt[100]);
        end
        reset = 1;
      end
    end
    @(negedge clk);
    reset = 0;
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sw_rst", int'(sw_rst), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_reached", int'(seen), 1);
    repeat (2) @(negedge clk);
    chk("midrst_stays_idle", int'(valid), 0);
    run(5, 12'h321, -1, 0, 0, '0, '0);
    sw_finish = 0;
    chk("midrst_rerun_first", obs_v_first, 2);
    chk("midrst_rerun_count", obs_v_cnt, L);
    chk("midrst_rerun_data", obs_data_bad, 0);
    chk("midrst_rerun_result", int'(obs_res_at_done), 'h321);
  endtask

  task automatic test_coincide;
    run(T - 1, 12'd2048, -1, 0, 0, '0, '0);
    sw_finish = 0;
    chk("coincide_done_cycle", obs_done_cyc, L + 2 + T);
    chk("coincide_result", int'(obs_res_at_done), 2048);
    chk("coincide_error", int'(obs_err_at_done), 0);
  endtask

  initial begin
    test_reset;
    test_stream;
    test_finish;
    test_timeout;
    test_busy_write;
    test_back_to_back;
    test_mid_reset;
    test_coincide;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
